// File: rtl/rr_burst_arbiter.sv
`default_nettype none
// ============================================================================
// rr_burst_arbiter : round-robin burst arbiter sharing one stream sink
// Revision: 1.0
// ============================================================================
module rr_burst_arbiter #(
   parameter int W       = 2,
   parameter int DW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [2**W-1:0]       req_valid,
   input  logic [2**W-1:0]       req_last,
   input  logic [(2**W)*DW-1:0]  req_data,
   output logic [2**W-1:0]       req_ready,
   output logic                  out_valid,
   output logic                  out_last,
   output logic [DW-1:0]         out_data,
   input  logic                  out_ready,
   output logic [2**W-1:0]       gnt,
   output logic [W-1:0]          owner,
   output logic                  busy,
   output logic                  timeout_err
);

   localparam int c_num_req = 2**W;
   localparam int c_cnt_w   = $clog2(TIMEOUT + 1);
   localparam logic [c_num_req-1:0] c_one = c_num_req'(1);
   localparam logic [c_cnt_w-1:0]   c_cnt_last = c_cnt_w'(TIMEOUT - 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [c_num_req-1:0] r_gnt, w_gnt_nxt;
   logic [c_num_req-1:0] r_mask, w_mask_nxt;
   logic [W-1:0]         r_owner, w_owner_nxt;
   logic [c_cnt_w-1:0]   r_idle_cnt, w_idle_cnt_nxt;
   logic                 r_timeout_err, w_timeout_err_nxt;

   logic [c_num_req-1:0] w_masked_req;
   logic [c_num_req-1:0] w_pick_src;
   logic [W-1:0]         w_win_idx;
   logic [c_num_req-1:0] w_win_above;
   logic [DW-1:0]        w_data_arr [c_num_req];
   logic                 w_own_valid;
   logic                 w_own_last;

   // Requesters strictly above the previous owner get first chance; otherwise
   // fall back to the plain lowest index, which completes the rotation.
   always_comb begin
      w_masked_req = req_valid & r_mask;
      w_pick_src   = (|w_masked_req) ? w_masked_req : req_valid;
      w_win_idx    = '0;
      for (int i = c_num_req - 1; i >= 0; i--) begin
         if (w_pick_src[i]) begin
            w_win_idx = W'(i);
         end
      end
   end

   generate
      for (genvar i = 0; i < c_num_req; i++) begin : g_req
         assign w_win_above[i] = (W'(i) > w_win_idx);
         assign w_data_arr[i]  = req_data[i*DW +: DW];
      end
   endgenerate

   assign w_own_valid = req_valid[r_owner];
   assign w_own_last  = req_last[r_owner];

   always_comb begin
      w_state_nxt       = r_state;
      w_gnt_nxt         = r_gnt;
      w_owner_nxt       = r_owner;
      w_mask_nxt        = r_mask;
      w_idle_cnt_nxt    = r_idle_cnt;
      w_timeout_err_nxt = 1'b0;
      out_valid         = 1'b0;
      out_last          = 1'b0;
      out_data          = '0;
      req_ready         = '0;

      case (r_state)
         S_IDLE: begin
            w_idle_cnt_nxt = '0;
            if (|req_valid) begin
               w_state_nxt = S_BUSY;
               w_gnt_nxt   = c_one << w_win_idx;
               w_owner_nxt = w_win_idx;
               w_mask_nxt  = w_win_above;
            end
         end

         S_BUSY: begin
            out_valid = w_own_valid;
            out_last  = w_own_last;
            out_data  = w_data_arr[r_owner];
            req_ready = r_gnt & {c_num_req{out_ready}};

            if (w_own_valid && out_ready && w_own_last) begin
               w_state_nxt    = S_IDLE;
               w_gnt_nxt      = '0;
               w_owner_nxt    = '0;
               w_idle_cnt_nxt = '0;
            end else if (w_own_valid) begin
               w_idle_cnt_nxt = '0;
            end else if (r_idle_cnt == c_cnt_last) begin
               // Owner went quiet too long; mask already points past it.
               w_state_nxt       = S_IDLE;
               w_gnt_nxt         = '0;
               w_owner_nxt       = '0;
               w_idle_cnt_nxt    = '0;
               w_timeout_err_nxt = 1'b1;
            end else begin
               w_idle_cnt_nxt = r_idle_cnt + 1'b1;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
            w_gnt_nxt   = '0;
            w_owner_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state       <= S_IDLE;
         r_gnt         <= '0;
         r_owner       <= '0;
         r_mask        <= '0;
         r_idle_cnt    <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_gnt         <= w_gnt_nxt;
         r_owner       <= w_owner_nxt;
         r_mask        <= w_mask_nxt;
         r_idle_cnt    <= w_idle_cnt_nxt;
         r_timeout_err <= w_timeout_err_nxt;
      end
   end

   assign gnt         = r_gnt;
   assign owner       = r_owner;
   assign busy        = (r_state == S_BUSY);
   assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_rr_burst_arbiter.sv
`default_nettype none
// ============================================================================
// tb_rr_burst_arbiter : randomized bench against a rotating-priority model
// Revision: 1.0
// ============================================================================
module tb_rr_burst_arbiter;

   localparam int W       = 2;
   localparam int DW      = 16;
   localparam int TIMEOUT = 4;
   localparam int N       = 2**W;

   logic            clock = 1'b0;
   logic            reset_n;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_last;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            out_valid;
   logic            out_last;
   logic [DW-1:0]   out_data;
   logic            out_ready;
   logic [N-1:0]    gnt;
   logic [W-1:0]    owner;
   logic            busy;
   logic            timeout_err;

   int n_vec = 0;
   int n_err = 0;

   // Model: burst lock flag, owner, last granted index, idle run length.
   bit m_busy;
   int m_owner;
   int m_ptr;
   int m_idle;
   bit m_err;

   rr_burst_arbiter #(.W(W), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .req_valid   (req_valid),
      .req_last    (req_last),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .out_valid   (out_valid),
      .out_last    (out_last),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .gnt         (gnt),
      .owner       (owner),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy  = 1'b0;
      m_owner = 0;
      m_ptr   = N - 1;
      m_idle  = 0;
      m_err   = 1'b0;
   endtask

   task automatic cycle(input logic [N-1:0] vmask, input int vpct, input int lpct,
                        input int rpct, input int rstpct);
      bit n_busy;
      int n_owner, n_ptr, n_idle;
      bit n_err_flag;
      logic [N-1:0]  e_gnt, e_rdy;
      logic [DW-1:0] e_data;

      reset_n = ($urandom_range(99) >= rstpct);
      for (int i = 0; i < N; i++) begin
         req_valid[i] = vmask[i] && ($urandom_range(99) < vpct);
         req_last[i]  = ($urandom_range(99) < lpct);
         req_data[i*DW +: DW] = DW'($urandom);
      end
      out_ready = ($urandom_range(99) < rpct);

      @(negedge clock);
      e_gnt  = m_busy ? (N'(1) << m_owner) : '0;
      e_rdy  = (m_busy && out_ready) ? (N'(1) << m_owner) : '0;
      e_data = m_busy ? req_data[m_owner*DW +: DW] : '0;
      check("gnt",         64'(gnt),         64'(e_gnt));
      check("owner",       64'(owner),       m_busy ? 64'(m_owner) : 64'd0);
      check("busy",        64'(busy),        64'(m_busy));
      check("timeout_err", 64'(timeout_err), 64'(m_err));
      check("out_valid",   64'(out_valid),   64'(m_busy && req_valid[m_owner]));
      check("out_last",    64'(out_last),    64'(m_busy && req_last[m_owner]));
      check("out_data",    64'(out_data),    64'(e_data));
      check("req_ready",   64'(req_ready),   64'(e_rdy));

      n_busy = m_busy; n_owner = m_owner; n_ptr = m_ptr; n_idle = m_idle;
      n_err_flag = 1'b0;
      if (!reset_n) begin
         n_busy = 1'b0; n_owner = 0; n_ptr = N - 1; n_idle = 0;
      end else if (!m_busy) begin
         bit found = 1'b0;
         for (int d = 1; d <= N; d++) begin
            int idx = (m_ptr + d) % N;
            if (!found && req_valid[idx]) begin
               found = 1'b1;
               n_owner = idx;
            end
         end
         if (found) begin
            n_busy = 1'b1;
            n_ptr  = n_owner;
            n_idle = 0;
         end
      end else if (req_valid[m_owner] && out_ready && req_last[m_owner]) begin
         n_busy = 1'b0;
         n_idle = 0;
      end else if (req_valid[m_owner]) begin
         n_idle = 0;
      end else begin
         n_idle = m_idle + 1;
         if (n_idle == TIMEOUT) begin
            n_busy = 1'b0;
            n_idle = 0;
            n_err_flag = 1'b1;
         end
      end

      @(posedge clock);
      m_busy = n_busy; m_owner = n_owner; m_ptr = n_ptr; m_idle = n_idle;
      m_err = n_err_flag;
      #1;
   endtask

   initial begin
      reset_n   = 1'b0;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      model_reset();

      // Reset state check while reset still held
      cycle('0, 0, 0, 100, 100);
      // Heavy contention, mostly-ready sink
      repeat (600) cycle('1, 90, 30, 80, 0);
      // Sparse owner valid: exercises idle counter and forced release
      repeat (600) cycle('1, 25, 40, 70, 0);
      // Lone requester with one-beat bursts
      repeat (60) cycle(N'(4), 100, 100, 100, 0);
      // Backpressure plus occasional mid-burst reset
      repeat (600) cycle('1, 70, 20, 30, 3);
      // Pointer reset: requesters 3 and 0 right after reset
      cycle('1, 100, 0, 100, 100);
      cycle(N'(9), 100, 0, 100, 0);
      repeat (20) cycle(N'(9), 100, 50, 100, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
